// File: rtl/isl58x_pkg.sv
// Shared definitions for the ISL58x DAC transmit path: data width, midscale code,
// FSM state encoding and a saturating counter helper.
package isl58x_pkg;

    localparam int ISL58X_DATA_W = 15;
    localparam logic [ISL58X_DATA_W-1:0] ISL58X_MIDSCALE = 15'h4000;

    typedef enum logic [1:0] {
        OFF,
        WAKE,
        STREAM,
        SLEEP
    } isl58x_tx_state_t;

    function automatic logic [15:0] isl58x_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/isl58x_sample_fifo.sv
// First-word fall-through sample FIFO with synchronous flush and occupancy output.
// o_level_next exposes the post-edge occupancy so the caller can register a ready flag.
module isl58x_sample_fifo
    import isl58x_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ISL58X_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [$clog2(DEPTH):0]   o_level_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        o_level_next = r_level;
        if (i_flush)
            o_level_next = '0;
        else if (w_do_push && !w_do_pop)
            o_level_next = r_level + LW'(1);
        else if (w_do_pop && !w_do_push)
            o_level_next = r_level - LW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= o_level_next;
        end
    end

    // NOTE: sample storage is deliberately not reset; the level and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/isl58x_dac_tx.sv
// ISL58x DAC pin driver: sample FIFO, divided DAC clock, CE/LOWP power sequencing.
// Optional macro ISL58X_MIDSCALE_ON_UNDERRUN_EN drives midscale on an underrun instead of holding.
module isl58x_dac_tx
    import isl58x_pkg::*;
#(
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int WAKE_TICKS = 8,
    parameter int IDLE_TICKS = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rtz_mode,
    input  logic [ISL58X_DATA_W-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_count,
    output logic                          isl58x_CE,
    output logic                          isl58x_CLK,
    output logic [ISL58X_DATA_W-1:0]      isl58x_D,
    output logic                          isl58x_LOWP,
    output logic                          isl58x_RTZ
);

    localparam int PW = $clog2(DIV);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int WW = $clog2(WAKE_TICKS + 1);
    localparam int IW = $clog2(IDLE_TICKS + 1);

    localparam logic [PW-1:0] PH_TICK = PW'(DIV / 2 - 1);
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    isl58x_tx_state_t           r_state;
    logic [PW-1:0]              r_phase;
    logic                       r_clk;
    logic [ISL58X_DATA_W-1:0]   r_d;
    logic                       r_ce;
    logic                       r_lowp;
    logic                       r_rtz;
    logic                       r_s_ready;
    logic [15:0]                r_underrun;
    logic [IW-1:0]              r_idle;
    logic [WW-1:0]              r_wake;

    logic [PW-1:0]              w_phase_next;
    logic                       w_tick;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_flush;
    logic [ISL58X_DATA_W-1:0]   w_fifo_data;
    logic                       w_fifo_empty;
    logic [LW-1:0]              w_level_next;

    assign w_phase_next = (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
    // The update tick is the edge on which the DAC clock falls, half a period before it latches.
    assign w_tick  = (r_state != OFF) && (r_phase == PH_TICK);
    assign w_push  = s_valid && r_s_ready;
    assign w_pop   = enable && (r_state == STREAM) && w_tick && !w_fifo_empty;
    assign w_flush = !enable || (r_state == OFF);

    isl58x_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ISL58X_DATA_W)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (w_flush),
        .i_push       (w_push),
        .i_data       (s_data),
        .i_pop        (w_pop),
        .o_data       (w_fifo_data),
        .o_empty      (w_fifo_empty),
        .o_level      (fifo_level),
        .o_level_next (w_level_next)
    );

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= OFF;
            r_phase    <= '0;
            r_clk      <= 1'b0;
            r_d        <= ISL58X_MIDSCALE;
            r_ce       <= 1'b0;
            r_lowp     <= 1'b1;
            r_rtz      <= 1'b0;
            r_s_ready  <= 1'b0;
            r_underrun <= '0;
            r_idle     <= '0;
            r_wake     <= '0;
        end else begin
            r_rtz     <= rtz_mode;
            r_s_ready <= enable && (w_level_next < LW'(FIFO_DEPTH));

            if (!enable) begin
                r_state <= OFF;
                r_phase <= '0;
                r_clk   <= 1'b0;
                r_d     <= ISL58X_MIDSCALE;
                r_ce    <= 1'b0;
                r_lowp  <= 1'b1;
            end else begin
                if (r_state != OFF) begin
                    r_phase <= w_phase_next;
                    r_clk   <= (w_phase_next < PH_HALF);
                end

                case (r_state)
                    OFF: begin
                        r_state <= WAKE;
                        r_ce    <= 1'b1;
                        r_lowp  <= 1'b0;
                        r_phase <= '0;
                        r_clk   <= 1'b1;
                        r_wake  <= '0;
                        r_d     <= ISL58X_MIDSCALE;
                    end
                    WAKE: begin
                        if (w_tick) begin
                            if (r_wake == WW'(WAKE_TICKS - 1))
                                r_state <= STREAM;
                            else
                                r_wake <= r_wake + WW'(1);
                        end
                    end
                    STREAM: begin
                        if (w_tick) begin
                            if (!w_fifo_empty) begin
                                r_d    <= w_fifo_data;
                                r_idle <= '0;
                            end else begin
                                r_underrun <= isl58x_sat_inc16(r_underrun);
`ifdef ISL58X_MIDSCALE_ON_UNDERRUN_EN
                                r_d <= ISL58X_MIDSCALE;
`endif
                                // The idle count restarts on entering SLEEP so the next STREAM visit gets a full window.
                                if (r_idle >= IW'(IDLE_TICKS - 1)) begin
                                    r_state <= SLEEP;
                                    r_lowp  <= 1'b1;
                                    r_idle  <= '0;
                                end else begin
                                    r_idle <= r_idle + IW'(1);
                                end
                            end
                        end
                    end
                    SLEEP: begin
                        if (!w_fifo_empty) begin
                            r_state <= WAKE;
                            r_lowp  <= 1'b0;
                            r_wake  <= '0;
                            r_d     <= ISL58X_MIDSCALE;
                        end
                    end
                    default: r_state <= OFF;
                endcase
            end
        end
    end

    assign s_ready        = r_s_ready;
    assign underrun_count = r_underrun;
    assign isl58x_CE      = r_ce;
    assign isl58x_CLK     = r_clk;
    assign isl58x_D       = r_d;
    assign isl58x_LOWP    = r_lowp;
    assign isl58x_RTZ     = r_rtz;

endmodule

// File: tb/tb_isl58x_dac_tx.sv
// Directed bench for isl58x_dac_tx: wake, stream, sleep, disable flush and async reset,
// with expectations for both settings of ISL58X_MIDSCALE_ON_UNDERRUN_EN.
module tb_isl58x_dac_tx;

    localparam int DIV        = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int WAKE_TICKS = 8;
    localparam int IDLE_TICKS = 16;
    localparam logic [14:0] MID = 15'h4000;
`ifdef ISL58X_MIDSCALE_ON_UNDERRUN_EN
    localparam logic [14:0] HOLD_EXP = 15'h4000;
`else
    localparam logic [14:0] HOLD_EXP = 15'h0010;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rtz_mode;
    logic [14:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  fifo_level;
    logic [15:0] underrun_count;
    logic        ce;
    logic        dclk;
    logic [14:0] d;
    logic        lowp;
    logic        rtz;

    isl58x_dac_tx #(
        .DIV        (DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WAKE_TICKS (WAKE_TICKS),
        .IDLE_TICKS (IDLE_TICKS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .rtz_mode       (rtz_mode),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .fifo_level     (fifo_level),
        .underrun_count (underrun_count),
        .isl58x_CE      (ce),
        .isl58x_CLK     (dclk),
        .isl58x_D       (d),
        .isl58x_LOWP    (lowp),
        .isl58x_RTZ     (rtz)
    );

    always #5 clk = ~clk;

    int n_pass     = 0;
    int n_total    = 0;
    int n_timeouts = 0;

    bit          mon_en    = 1'b0;
    int          align_err = 0;
    int          ready_err = 0;
    int          max_level = 0;
    logic        prev_dclk;
    logic [14:0] prev_d;

    // D may only move on a sampled high-to-low step of the DAC clock; full FIFO must drop s_ready.
    always @(negedge clk) begin
        if (mon_en) begin
            if (d !== prev_d && !(prev_dclk === 1'b1 && dclk === 1'b0)) align_err++;
            if (fifo_level == 5'd16 && s_ready) ready_err++;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        prev_d    = d;
        prev_dclk = dclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic wait_fall();
        int n = 0;
        while (dclk !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 4 * DIV) begin n_timeouts++; return; end
        end
        do begin
            @(negedge clk);
            n++;
            if (n > 4 * DIV) begin n_timeouts++; return; end
        end while (dclk !== 1'b0);
    endtask

    task automatic push_seq(input int first, input int count);
        int v = first;
        int guard = 0;
        while (v < first + count && guard < 200) begin
            if (s_ready) begin
                s_valid = 1'b1;
                s_data  = 15'(v);
                v++;
            end else begin
                s_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        if (v < first + count) n_timeouts++;
    endtask

    task automatic wait_dclk_high();
        int n = 0;
        while (dclk !== 1'b1 && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (dclk !== 1'b1) n_timeouts++;
    endtask

    initial begin
        int  mids;
        int  k_sleep;
        time t0;

        reset = 1'b1; enable = 1'b0; rtz_mode = 1'b0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);

        check("rst_ce", ce, 0);
        check("rst_clk", dclk, 0);
        check("rst_d", d, MID);
        check("rst_lowp", lowp, 1);
        check("rst_rtz", rtz, 0);
        check("rst_ready", s_ready, 0);
        check("rst_level", fifo_level, 0);
        check("rst_underrun", underrun_count, 0);

        reset = 1'b0;
        @(negedge clk);

        // Wake with no data, then empty STREAM ticks
        enable = 1'b1;
        @(negedge clk);
        check("wake_ce", ce, 1);
        check("wake_lowp", lowp, 0);
        check("wake_d", d, MID);
        for (int i = 0; i < WAKE_TICKS; i++) begin
            wait_fall();
            check("wake_mid", d, MID);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_fall();
            check("underrun_inc", underrun_count, i);
        end
        check("stream_lowp", lowp, 0);

        // Disable with an empty FIFO
        enable = 1'b0;
        @(negedge clk);
        check("off_ce", ce, 0);
        check("off_clk", dclk, 0);
        check("off_d", d, MID);
        check("off_lowp", lowp, 1);
        check("off_underrun_kept", underrun_count, 3);

        // Re-wake and stream 0x0001..0x0010; pushes fill the FIFO during WAKE
        enable = 1'b1;
        mon_en = 1'b1;
        fork
            push_seq(1, 16);
            begin
                mids = 0;
                for (int i = 0; i < 12; i++) begin
                    wait_fall();
                    if (d != MID) break;
                    mids++;
                end
                check("wake_periods", mids, WAKE_TICKS);
                check("first_sample", d, 1);
                t0 = $time;
                for (int v = 2; v <= 16; v++) begin
                    wait_fall();
                    check("stream_sample", d, v);
                end
                check("sample_spacing", 32'(($time - t0) / 10), 15 * DIV);
            end
        join
        mon_en = 1'b0;
        check("d_on_fall_only", align_err, 0);
        check("ready_low_full", ready_err, 0);
        check("max_level", max_level, FIFO_DEPTH);
        check("no_underrun_fed", underrun_count, 3);

        // Starve the FIFO until SLEEP
        k_sleep = 0;
        while (k_sleep < 40) begin
            wait_fall();
            k_sleep++;
            if (lowp) break;
        end
        check("idle_ticks", k_sleep, IDLE_TICKS);
        check("sleep_ce", ce, 1);
        check("sleep_lowp", lowp, 1);
        check("sleep_underrun", underrun_count, 19);
        check("underrun_d", d, HOLD_EXP);

        // A sample wakes the DAC; it appears after a full wake window
        push_seq(15'h1234, 1);
        @(negedge clk);
        check("rewake_lowp", lowp, 0);
        check("rewake_d", d, MID);
        mids = 0;
        for (int i = 0; i < 12; i++) begin
            wait_fall();
            if (d != MID) break;
            mids++;
        end
        check("rewake_periods", mids, WAKE_TICKS);
        check("rewake_sample", d, 15'h1234);
        check("rewake_underrun", underrun_count, 19);

        // Disable with five samples queued and the DAC clock high
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        push_seq(32'h100, 5);
        wait_dclk_high();
        check("pre_flush_level", fifo_level, 5);
        check("pre_flush_clk", dclk, 1);
        enable = 1'b0;
        @(negedge clk);
        check("flush_level", fifo_level, 0);
        check("flush_ce", ce, 0);
        check("flush_clk", dclk, 0);
        check("flush_d", d, MID);
        check("flush_lowp", lowp, 1);
        check("flush_underrun", underrun_count, 19);

        // Asynchronous reset mid-stream during a DAC clock high phase
        rtz_mode = 1'b1;
        enable   = 1'b1;
        push_seq(15'h0ABC, 1);
        for (int i = 0; i < 12; i++) begin
            wait_fall();
            if (d == 15'h0ABC) break;
        end
        check("pre_rst_sample", d, 15'h0ABC);
        check("pre_rst_rtz", rtz, 1);
        wait_dclk_high();
        #2 reset = 1'b1;
        #1;
        check("arst_ce", ce, 0);
        check("arst_clk", dclk, 0);
        check("arst_d", d, MID);
        check("arst_lowp", lowp, 1);
        check("arst_rtz", rtz, 0);
        check("arst_ready", s_ready, 0);
        check("arst_level", fifo_level, 0);
        check("arst_underrun", underrun_count, 0);
        rtz_mode = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ce", ce, 1);
        check("post_rst_lowp", lowp, 0);
        for (int i = 0; i < WAKE_TICKS; i++) begin
            wait_fall();
            check("post_rst_mid", d, MID);
        end
        wait_fall();
        check("post_rst_underrun", underrun_count, 1);

        check("no_timeouts", n_timeouts, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
